dp_issue: RTL and testbench

DP_ISSUE -- requirements
Module: dp_issue

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/cond_check.sv | 37 +++
 rtl/dp_issue.sv | 136 +++++++++++++
 tb/tb_dp_issue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the data-processing issue stage and the ALU:
// opcode and condition-code encodings, the issue-stage state type, and the
// ARM rotated-immediate expansion helper.
package cpu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_FULL_S = 2'd2
    } issue_state_e;

    // Zero-extended imm8 rotated right by 2*rot. Rotating a doubled copy
    // avoids a special case for rot = 0.
    function automatic logic [31:0] imm_rotate(input logic [7:0] imm8, input logic [3:0] rot);
        logic [63:0] dbl;
        logic [63:0] shifted;
        dbl     = {24'd0, imm8, 24'd0, imm8};
        shifted = dbl >> {rot, 1'b0};
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition evaluation.
// Ports: cond - condition field; nzcv - current flags {N,Z,C,V};
//        pass - 1 when the instruction should execute (1111 never passes).
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_issue.sv
// Issue stage for ARM data-processing instructions: decodes, condition-checks
// and rejects instructions, then holds one issued instruction in a single
// output register for the ALU/writeback, and owns the CPSR NZCV flags.
// Ports: clk/rst_n - clock, async active-low reset;
//        in_valid/in_ready/in_instr - instruction input handshake;
//        rn_idx/rm_idx, rn_data/rm_data - register-file read port;
//        out_valid/out_ready and alu_* / rd_* - registered issue outputs;
//        alu_n/z/c/v - ALU flag results for the issued instruction;
//        cpsr_nzcv - architectural flags; undef_pulse - rejected instruction.
//
// state     | meaning
// ST_EMPTY  | no instruction held, out_valid low
// ST_FULL   | holding an instruction that does not update flags
// ST_FULL_S | holding an S instruction; flags written when it drains
module dp_issue
    import cpu_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] RESET_NZCV = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    output logic [3:0]            rn_idx,
    output logic [3:0]            rm_idx,
    input  logic [DATA_WIDTH-1:0] rn_data,
    input  logic [DATA_WIDTH-1:0] rm_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  alu_enable,
    output logic [3:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_operand1,
    output logic [DATA_WIDTH-1:0] alu_operand2,
    output logic                  alu_carry_in,
    output logic                  alu_flag_update,
    output logic [3:0]            rd_idx,
    output logic                  rd_we,
    input  logic                  alu_n,
    input  logic                  alu_z,
    input  logic                  alu_c,
    input  logic                  alu_v,
    output logic [3:0]            cpsr_nzcv,
    output logic                  undef_pulse
);

    issue_state_e state;

    logic [3:0] f_cond, f_op, f_rd;
    logic [1:0] f_class;
    logic       f_imm, f_s;
    logic       is_compare, uses_carry, flag_hazard;
    logic       cond_pass, bad, accept, load, drain;
    logic [DATA_WIDTH-1:0] operand2;

    assign f_cond  = in_instr[31:28];
    assign f_class = in_instr[27:26];
    assign f_imm   = in_instr[25];
    assign f_op    = in_instr[24:21];
    assign f_s     = in_instr[20];
    assign f_rd    = in_instr[15:12];
    assign rn_idx  = in_instr[19:16];
    assign rm_idx  = in_instr[3:0];

    assign is_compare = (f_op == OP_TST) || (f_op == OP_TEQ) || (f_op == OP_CMP) || (f_op == OP_CMN);
    assign uses_carry = (f_op == OP_ADC) || (f_op == OP_SBC) || (f_op == OP_RSC);
    // Anything that reads flags must wait until a held S instruction has written them.
    assign flag_hazard = (f_cond != COND_AL) || uses_carry;

    cond_check u_cond_check (
        .cond (f_cond),
        .nzcv (cpsr_nzcv),
        .pass (cond_pass)
    );

    assign out_valid = (state != ST_EMPTY);

    always_comb begin
        in_ready = 1'b1;
        case (state)
            ST_EMPTY:  in_ready = 1'b1;
            ST_FULL:   in_ready = out_ready;
            ST_FULL_S: in_ready = out_ready & ~flag_hazard;
            default:   in_ready = 1'b1;
        endcase
    end

    // Malformed encodings take priority over the condition check.
    assign bad = (f_class != 2'b00) || (!f_imm && (in_instr[11:4] != 8'd0))
               || (is_compare && !f_s) || (f_cond == COND_NV);

    assign accept = in_valid & in_ready;
    assign load   = accept & ~bad & cond_pass;
    assign drain  = out_valid & out_ready;

    assign operand2 = f_imm ? DATA_WIDTH'(imm_rotate(in_instr[7:0], in_instr[11:8])) : rm_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_EMPTY;
            alu_enable      <= 1'b0;
            alu_opcode      <= 4'd0;
            alu_operand1    <= '0;
            alu_operand2    <= '0;
            alu_carry_in    <= 1'b0;
            alu_flag_update <= 1'b0;
            rd_idx          <= 4'd0;
            rd_we           <= 1'b0;
            cpsr_nzcv       <= RESET_NZCV;
            undef_pulse     <= 1'b0;
        end else begin
            undef_pulse <= accept & bad;
            if (drain && (state == ST_FULL_S)) begin
                cpsr_nzcv <= {alu_n, alu_z, alu_c, alu_v};
            end
            if (load) begin
                state           <= f_s ? ST_FULL_S : ST_FULL;
                alu_enable      <= 1'b1;
                alu_opcode      <= f_op;
                alu_operand1    <= rn_data;
                alu_operand2    <= operand2;
                alu_carry_in    <= cpsr_nzcv[1];
                alu_flag_update <= f_s;
                rd_idx          <= f_rd;
                rd_we           <= ~is_compare;
            end else if (drain) begin
                state           <= ST_EMPTY;
                alu_enable      <= 1'b0;
                alu_flag_update <= 1'b0;
                rd_we           <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dp_issue.sv
module tb_dp_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [3:0]  rn_idx, rm_idx;
    logic [31:0] rn_data = '0, rm_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        alu_enable;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_operand1, alu_operand2;
    logic        alu_carry_in, alu_flag_update;
    logic [3:0]  rd_idx;
    logic        rd_we;
    logic        alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
    logic [3:0]  cpsr_nzcv;
    logic        undef_pulse;

    dp_issue #(.DATA_WIDTH(32), .RESET_NZCV(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rn_idx(rn_idx), .rm_idx(rm_idx), .rn_data(rn_data), .rm_data(rm_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_enable(alu_enable), .alu_opcode(alu_opcode),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_carry_in(alu_carry_in), .alu_flag_update(alu_flag_update),
        .rd_idx(rd_idx), .rd_we(rd_we),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .cpsr_nzcv(cpsr_nzcv), .undef_pulse(undef_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic obs_ready;

    // Transaction-level model of the held instruction and the flags.
    bit          m_valid, m_s, m_en, m_we, m_fu, m_cin, m_undef;
    logic [3:0]  m_op, m_rd, m_cpsr;
    logic [31:0] m_op1, m_op2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] cond, input logic i, input logic [3:0] op,
                                        input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                        input logic [11:0] op2);
        return {cond, 2'b00, i, op, s, rn, rd, op2};
    endfunction

    function automatic bit m_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Rotate one bit at a time, 2*rot times.
    function automatic logic [31:0] m_imm(input logic [7:0] imm, input logic [3:0] rot);
        logic [31:0] x;
        x = {24'd0, imm};
        for (int i = 0; i < 2 * int'(rot); i++) x = {x[0], x[31:1]};
        return x;
    endfunction

    function automatic bit m_ready(input logic [31:0] ins, input bit ordy);
        int op;
        op = int'(ins[24:21]);
        if (!m_valid) return 1'b1;
        if (!m_s) return ordy;
        return ordy && (ins[31:28] == 4'he) && !(op >= 5 && op <= 7);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_s = 0; m_en = 0; m_we = 0; m_fu = 0; m_cin = 0; m_undef = 0;
        m_op = 0; m_rd = 0; m_cpsr = 4'b0000; m_op1 = 0; m_op2 = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("alu_enable", alu_enable, m_en);
        chk("rd_we", rd_we, m_we);
        chk("alu_flag_update", alu_flag_update, m_fu);
        chk("alu_opcode", alu_opcode, m_op);
        chk("alu_operand1", alu_operand1, m_op1);
        chk("alu_operand2", alu_operand2, m_op2);
        chk("alu_carry_in", alu_carry_in, m_cin);
        chk("rd_idx", rd_idx, m_rd);
        chk("cpsr_nzcv", cpsr_nzcv, m_cpsr);
        chk("undef_pulse", undef_pulse, m_undef);
    endtask

    // One clock: drive after a falling edge, check handshake, clock, check outputs.
    task automatic cycle(input bit v, input logic [31:0] ins, input bit ordy, input logic [3:0] fl);
        logic [31:0] rn_v, rm_v;
        logic [3:0]  op, nc;
        bit rdy, acc, bad, ld, drain, cmp;
        rn_v = $urandom;
        rm_v = $urandom;
        in_valid = v; in_instr = ins; out_ready = ordy;
        rn_data = rn_v; rm_data = rm_v;
        {alu_n, alu_z, alu_c, alu_v} = fl;
        #1;
        rdy = m_ready(ins, ordy);
        obs_ready = in_ready;
        chk("in_ready", in_ready, rdy);
        chk("rn_idx", rn_idx, ins[19:16]);
        chk("rm_idx", rm_idx, ins[3:0]);
        @(posedge clk);
        op    = ins[24:21];
        cmp   = (op >= 4'd8) && (op <= 4'd11);
        acc   = v && rdy;
        drain = m_valid && ordy;
        bad   = (ins[27:26] != 2'b00) || (!ins[25] && ins[11:4] != 8'd0)
              || (cmp && !ins[20]) || (ins[31:28] == 4'hf);
        ld    = acc && !bad && m_pass(ins[31:28], m_cpsr);
        nc    = (drain && m_s) ? fl : m_cpsr;
        if (ld) begin
            m_op = op; m_op1 = rn_v;
            m_op2 = ins[25] ? m_imm(ins[7:0], ins[11:8]) : rm_v;
            m_cin = m_cpsr[1]; m_fu = ins[20]; m_rd = ins[15:12];
            m_we = !cmp; m_en = 1; m_valid = 1; m_s = ins[20];
        end else if (drain) begin
            m_valid = 0; m_s = 0; m_en = 0; m_we = 0; m_fu = 0;
        end
        m_cpsr  = nc;
        m_undef = acc && bad;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        {alu_n, alu_z, alu_c, alu_v} = 4'b1111;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", in_ready, 1'b1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        x = $urandom;
        if ($urandom_range(0, 3) != 0) x[31:28] = 4'he;
        if ($urandom_range(0, 7) != 0) x[27:26] = 2'b00;
        if (!x[25] && $urandom_range(0, 7) != 0) x[11:4] = 8'd0;
        return x;
    endfunction

    logic [31:0] addeq;
    logic [31:0] snap_op1, snap_op2;
    logic [3:0]  snap_cpsr, snap_rd;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        chk("reset_cpsr", cpsr_nzcv, 4'b0000);
        chk("reset_out_valid", out_valid, 1'b0);

        cycle(1, enc(4'he, 1, 4'b1101, 0, 4'd0, 4'd1, 12'h0FF), 1, 4'b0000);
        chk("mov_out_valid", out_valid, 1'b1);
        chk("mov_opcode", alu_opcode, 4'b1101);
        chk("mov_operand2", alu_operand2, 32'h0000_00FF);
        chk("mov_rd_idx", rd_idx, 4'd1);
        chk("mov_rd_we", rd_we, 1'b1);

        cycle(1, enc(4'he, 1, 4'b1101, 0, 4'd0, 4'd2, 12'hF3F), 1, 4'b0000);
        chk("rot15_operand2", alu_operand2, 32'h0000_00FC);
        cycle(1, enc(4'he, 1, 4'b1101, 0, 4'd0, 4'd3, 12'h13F), 1, 4'b0000);
        chk("rot1_operand2", alu_operand2, 32'hC000_000F);

        // SUBS then ADDEQ: stall one cycle while SUBS writes Z.
        addeq = enc(4'h0, 1, 4'b0100, 0, 4'd5, 4'd6, 12'h001);
        cycle(1, enc(4'he, 0, 4'b0010, 1, 4'd3, 4'd2, 12'h004), 1, 4'b0000);
        cycle(1, addeq, 1, 4'b0100);
        chk("addeq_stall_ready", obs_ready, 1'b0);
        chk("subs_cpsr_z", cpsr_nzcv[2], 1'b1);
        cycle(1, addeq, 1, 4'b0000);
        chk("addeq_issued", out_valid, 1'b1);
        chk("addeq_opcode", alu_opcode, 4'b0100);

        // MOVS #0 with clear flags, then ADDEQ fails its condition.
        cycle(1, enc(4'he, 1, 4'b1101, 1, 4'd0, 4'd0, 12'h000), 1, 4'b0000);
        cycle(0, 32'd0, 1, 4'b0000);
        chk("movs_cpsr", cpsr_nzcv, 4'b0000);
        cycle(1, addeq, 1, 4'b0000);
        chk("condfail_out_valid", out_valid, 1'b0);
        chk("condfail_undef", undef_pulse, 1'b0);

        // Back-pressure with a FULL stage.
        cycle(1, enc(4'he, 0, 4'b0100, 0, 4'd1, 4'd7, 12'h002), 1, 4'b0000);
        snap_op1 = alu_operand1; snap_op2 = alu_operand2;
        snap_rd = rd_idx; snap_cpsr = cpsr_nzcv;
        for (int k = 0; k < 3; k++) begin
            cycle(1, enc(4'he, 1, 4'b1101, 0, 4'd0, 4'd8, 12'h055), 0, 4'b1111);
            chk("stall_in_ready", obs_ready, 1'b0);
            chk("stall_operand1", alu_operand1, snap_op1);
            chk("stall_operand2", alu_operand2, snap_op2);
            chk("stall_rd_idx", rd_idx, snap_rd);
            chk("stall_cpsr", cpsr_nzcv, snap_cpsr);
        end
        cycle(0, 32'd0, 1, 4'b1111);
        chk("drain_cpsr_unchanged", cpsr_nzcv, snap_cpsr);
        chk("drain_out_valid", out_valid, 1'b0);

        // Rejections.
        cycle(1, enc(4'he, 1, 4'b1010, 0, 4'd1, 4'd0, 12'h001), 1, 4'b0000);
        chk("cmp_s0_undef", undef_pulse, 1'b1);
        chk("cmp_s0_out_valid", out_valid, 1'b0);
        cycle(0, 32'd0, 1, 4'b0000);
        chk("cmp_s0_undef_once", undef_pulse, 1'b0);
        cycle(1, enc(4'he, 1, 4'b1101, 0, 4'd0, 4'd1, 12'h001) | 32'h0400_0000, 1, 4'b0000);
        chk("class01_undef", undef_pulse, 1'b1);
        chk("class01_out_valid", out_valid, 1'b0);
        cycle(0, 32'd0, 1, 4'b0000);
        chk("class01_undef_once", undef_pulse, 1'b0);

        // Reset with an S instruction held: no issue, no flag write.
        cycle(1, enc(4'he, 1, 4'b1101, 1, 4'd0, 4'd9, 12'h0AA), 0, 4'b0000);
        do_reset();
        cycle(0, 32'd0, 1, 4'b1111);
        chk("midreset_cpsr", cpsr_nzcv, 4'b0000);
        chk("midreset_out_valid", out_valid, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
